// File: rtl/ukf_mean_sched.sv
// Sigma-point sequencer for the UKF weighted-mean accumulator: center term, then N_STATE pairs.
// Optional UKF_SCHED_PERF_EN adds a run_cnt output counting completed passes.
module ukf_mean_sched #(
  parameter int DATA_W  = 32,
  parameter int N_STATE = 6,
  parameter int ADDR_W  = 4,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] w0,
  input  logic [DATA_W-1:0] wi,
  output logic              busy,
  output logic              done,
  output logic              sig_rd_en,
  output logic [ADDR_W-1:0] sig_rd_addr1,
  output logic [ADDR_W-1:0] sig_rd_addr2,
  output logic              acc_clr,
  output logic              acc_en,
  output logic [DATA_W-1:0] acc_w,
  output logic              acc_zero2,
  output logic              mean_cap
`ifdef UKF_SCHED_PERF_EN
  ,
  output logic [31:0]       run_cnt
`endif
);

  localparam int CNT_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CENTER,
    ST_PAIR,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [DATA_W-1:0]  w0_reg, w0_next;
  logic [DATA_W-1:0]  wi_reg, wi_next;

  logic               busy_next, done_next, rd_en_next, clr_next;
  logic [ADDR_W-1:0]  addr1_next, addr2_next;

  // Read tags travel alongside the memory latency so the accumulator sees them with the data.
  logic [MEM_LAT-1:0] vld_pipe;
  logic [MEM_LAT-1:0] z_pipe;
  logic [DATA_W-1:0]  w_pipe [MEM_LAT];
  logic               tag_vld;
  logic               tag_z;
  logic [DATA_W-1:0]  tag_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      w0_reg    <= '0;
      wi_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      w0_reg    <= w0_next;
      wi_reg    <= wi_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    w0_next    = w0_reg;
    wi_next    = wi_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start && !abort) begin
          state_next = ST_CENTER;
          cnt_next   = '0;
          w0_next    = w0;
          wi_next    = wi;
        end
      end
      ST_CENTER: begin
        state_next = ST_PAIR;
        cnt_next   = CNT_W'(1);
      end
      ST_PAIR: begin
        if (cnt_reg == CNT_W'(N_STATE)) begin
          state_next = ST_DRAIN;
          cnt_next   = CNT_W'(1);
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (cnt_reg == CNT_W'(MEM_LAT)) begin
          state_next = ST_DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
    if (abort) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
    end
  end

  // Outputs are decoded from the next state so every port comes straight from a flop.
  always_comb begin
    busy_next  = (state_next != ST_IDLE);
    done_next  = (state_next == ST_DONE);
    clr_next   = (state_next == ST_CENTER);
    rd_en_next = (state_next == ST_CENTER) || (state_next == ST_PAIR);
    addr1_next = '0;
    addr2_next = '0;
    if (state_next == ST_PAIR) begin
      addr1_next = ADDR_W'(cnt_next);
      addr2_next = ADDR_W'(cnt_next) + ADDR_W'(N_STATE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      mean_cap     <= 1'b0;
      acc_clr      <= 1'b0;
      sig_rd_en    <= 1'b0;
      sig_rd_addr1 <= '0;
      sig_rd_addr2 <= '0;
    end else begin
      busy         <= busy_next;
      done         <= done_next;
      mean_cap     <= done_next;
      acc_clr      <= clr_next;
      sig_rd_en    <= rd_en_next;
      sig_rd_addr1 <= addr1_next;
      sig_rd_addr2 <= addr2_next;
    end
  end

  // The read issued this cycle is the center term exactly when acc_clr is up.
  assign tag_vld = sig_rd_en;
  assign tag_z   = sig_rd_en && acc_clr;
  assign tag_w   = !sig_rd_en ? '0 : (acc_clr ? w0_reg : wi_reg);

  generate
    for (genvar gi = 0; gi < MEM_LAT; gi++) begin : g_tag_pipe
      logic              vld_in;
      logic              z_in;
      logic [DATA_W-1:0] w_in;
      if (gi == 0) begin : g_head
        assign vld_in = tag_vld;
        assign z_in   = tag_z;
        assign w_in   = tag_w;
      end else begin : g_body
        assign vld_in = vld_pipe[gi-1];
        assign z_in   = z_pipe[gi-1];
        assign w_in   = w_pipe[gi-1];
      end
      always_ff @(posedge clk) begin
        if (rst || abort) begin
          vld_pipe[gi] <= 1'b0;
          z_pipe[gi]   <= 1'b0;
          w_pipe[gi]   <= '0;
        end else begin
          vld_pipe[gi] <= vld_in;
          z_pipe[gi]   <= z_in;
          w_pipe[gi]   <= w_in;
        end
      end
    end
  endgenerate

  assign acc_en    = vld_pipe[MEM_LAT-1];
  assign acc_zero2 = z_pipe[MEM_LAT-1];
  assign acc_w     = w_pipe[MEM_LAT-1];

`ifdef UKF_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt <= '0;
    end else if (done) begin
      run_cnt <= run_cnt + 32'd1;
    end
  end
`endif

endmodule
